// File: rtl/chain_driver_sequencer.sv
// rtl/chain_driver_sequencer.sv - multi-channel Next_Edge burst sequencer with thermometer drive-strength enables
// Optional macro CHAIN_DRV_ABORT_EN enables the Abort input and the Aborted flag.
module chain_driver_sequencer #(
    parameter int CHANNELS   = 4,
    parameter int STAGES     = 4,
    parameter int EDGE_CNT_W = 8,
    parameter int GAP_W      = 4,
    localparam int STR_W     = $clog2(STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Start,
    input  logic [EDGE_CNT_W-1:0]        Num_Edges,
    input  logic [GAP_W-1:0]             Gap,
    input  logic [STR_W-1:0]             Strength,
    input  logic [CHANNELS-1:0]          Chan_Mask,
    input  logic                         Abort,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Aborted,
    output logic [EDGE_CNT_W-1:0]        Edge_Count,
    output logic [CHANNELS-1:0]          Next_Edge_LowV,
    output logic [CHANNELS*STAGES-1:0]   Drive_En
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LAUNCH,
        S_GAP,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [EDGE_CNT_W-1:0] num_q;
    logic [GAP_W-1:0]      gap_q;
    logic [STR_W-1:0]      str_q;
    logic [CHANNELS-1:0]   mask_q;
    logic [EDGE_CNT_W-1:0] edge_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [CHANNELS-1:0]   next_edge;
    logic [STR_W-1:0]      str_sat;
    logic [EDGE_CNT_W-1:0] edge_cnt_inc;
    logic                  last_edge;
    logic                  abort_req;
    logic                  active;

`ifdef CHAIN_DRV_ABORT_EN
    assign abort_req = Abort;
`else
    logic abort_unused;
    assign abort_unused = Abort;
    assign abort_req    = 1'b0;
`endif

    assign str_sat      = (Strength > STR_W'(STAGES)) ? STR_W'(STAGES) : Strength;
    assign edge_cnt_inc = edge_cnt + EDGE_CNT_W'(1);
    assign last_edge    = (edge_cnt_inc == num_q);
    assign active       = (state == S_ARM) || (state == S_LAUNCH) || (state == S_GAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Gap=0 chains LAUNCH back-to-back so edges are spaced Gap+1 clocks apart.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (Start) state_next = S_ARM;
            end
            S_ARM: begin
                if (abort_req || num_q == '0) state_next = S_DONE;
                else                          state_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (abort_req || last_edge) state_next = S_DONE;
                else if (gap_q == '0)       state_next = S_LAUNCH;
                else                        state_next = S_GAP;
            end
            S_GAP: begin
                if (abort_req)          state_next = S_DONE;
                else if (gap_cnt == '0) state_next = S_LAUNCH;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q     <= '0;
            gap_q     <= '0;
            str_q     <= '0;
            mask_q    <= '0;
            edge_cnt  <= '0;
            gap_cnt   <= '0;
            next_edge <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        num_q    <= Num_Edges;
                        gap_q    <= Gap;
                        str_q    <= str_sat;
                        mask_q   <= Chan_Mask;
                        edge_cnt <= '0;
                    end
                end
                S_LAUNCH: begin
                    if (!abort_req) begin
                        next_edge <= next_edge ^ mask_q;
                        edge_cnt  <= edge_cnt_inc;
                        if (gap_q != '0) gap_cnt <= gap_q - GAP_W'(1);
                    end
                end
                S_GAP: begin
                    if (!abort_req && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CHAIN_DRV_ABORT_EN
    logic aborted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else if (state == S_IDLE && Start) begin
            aborted_q <= 1'b0;
        end else if (active && abort_req) begin
            aborted_q <= 1'b1;
        end
    end

    assign Aborted = aborted_q;
`else
    assign Aborted = 1'b0;
`endif

    always_comb begin
        Drive_En = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < STAGES; i++) begin
                Drive_En[c*STAGES + i] = active && mask_q[c] && (i < int'(str_q));
            end
        end
    end

    assign Busy           = active;
    assign Done           = (state == S_DONE);
    assign Edge_Count     = edge_cnt;
    assign Next_Edge_LowV = next_edge;

endmodule

// File: tb/tb_chain_driver_sequencer.sv
// tb/tb_chain_driver_sequencer.sv - self-checking bench for chain_driver_sequencer
module tb_chain_driver_sequencer;
    localparam int CH = 4;
    localparam int ST = 4;
    localparam int EW = 8;
    localparam int GW = 4;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            Start;
    logic [EW-1:0]   Num_Edges;
    logic [GW-1:0]   Gap;
    logic [SW-1:0]   Strength;
    logic [CH-1:0]   Chan_Mask;
    logic            Abort;
    logic            Busy;
    logic            Done;
    logic            Aborted;
    logic [EW-1:0]   Edge_Count;
    logic [CH-1:0]   Next_Edge_LowV;
    logic [CH*ST-1:0] Drive_En;

    int total = 0;
    int bad   = 0;
    logic [CH-1:0] level;

    always #5 clk = ~clk;

    chain_driver_sequencer #(
        .CHANNELS(CH), .STAGES(ST), .EDGE_CNT_W(EW), .GAP_W(GW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Num_Edges(Num_Edges), .Gap(Gap),
        .Strength(Strength), .Chan_Mask(Chan_Mask), .Abort(Abort), .Busy(Busy),
        .Done(Done), .Aborted(Aborted), .Edge_Count(Edge_Count),
        .Next_Edge_LowV(Next_Edge_LowV), .Drive_En(Drive_En)
    );

    typedef struct {
        int          n;
        int          g;
        int          s;
        logic [3:0]  m;
        logic [15:0] de;
        int          final_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_de(input int s, input logic [3:0] m);
        logic [15:0] r;
        int sat;
        sat = (s > ST) ? ST : s;
        r = '0;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < ST; i++)
                r[c*ST + i] = m[c] && (i < sat);
        return r;
    endfunction

    task automatic run_burst(input int n, input int g, input int s, input logic [3:0] m,
                             input logic [15:0] de, input int final_cnt, input bit noise);
        int done_t;
        int cnt;
        logic [3:0] base;
        done_t = (n == 0) ? 1 : 2 + (n - 1) * (g + 1);
        base = level;
        @(negedge clk);
        Num_Edges = EW'(n); Gap = GW'(g); Strength = SW'(s); Chan_Mask = m; Start = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= done_t + 1; t++) begin
            @(negedge clk);
            cnt = 0;
            for (int j = 0; j < n; j++) if (2 + j * (g + 1) <= t) cnt++;
            chk("busy", 32'(Busy), 32'(t < done_t));
            chk("done", 32'(Done), 32'(t == done_t));
            chk("edge_count", 32'(Edge_Count), 32'(cnt));
            chk("next_edge", 32'(Next_Edge_LowV), 32'(base ^ ((cnt % 2 == 1) ? m : 4'h0)));
            chk("drive_en", 32'(Drive_En), 32'((t < done_t) ? de : 16'h0));
            chk("aborted", 32'(Aborted), 32'd0);
            Start = (noise && t < done_t) ? 1'($urandom_range(1)) : 1'b0;
            if (noise) begin
                Num_Edges = EW'($urandom); Gap = GW'($urandom);
                Strength = SW'($urandom); Chan_Mask = CH'($urandom);
            end
        end
        chk("final_count", 32'(Edge_Count), 32'(final_cnt));
        level = base ^ ((n % 2 == 1) ? m : 4'h0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{n:3, g:2,  s:2, m:4'h5, de:16'h0303, final_cnt:3};
        vecs[1] = '{n:0, g:3,  s:1, m:4'hF, de:16'h1111, final_cnt:0};
        vecs[2] = '{n:6, g:0,  s:7, m:4'hF, de:16'hFFFF, final_cnt:6};
        vecs[3] = '{n:5, g:1,  s:0, m:4'hA, de:16'h0000, final_cnt:5};
        vecs[4] = '{n:5, g:2,  s:3, m:4'h0, de:16'h0000, final_cnt:5};
        vecs[5] = '{n:1, g:15, s:4, m:4'h8, de:16'hF000, final_cnt:1};
        vecs[6] = '{n:4, g:1,  s:1, m:4'h2, de:16'h0010, final_cnt:4};

        rst_n = 1'b0; Start = 1'b0; Num_Edges = '0; Gap = '0; Strength = '0;
        Chan_Mask = '0; Abort = 1'b0; level = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_count", 32'(Edge_Count), 32'd0);
        chk("rst_edges", 32'(Next_Edge_LowV), 32'd0);
        chk("rst_drive", 32'(Drive_En), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++)
            run_burst(vecs[v].n, vecs[v].g, vecs[v].s, vecs[v].m, vecs[v].de, vecs[v].final_cnt, 1'b0);

        // Reset landing in the middle of a GAP wait must clear everything at once.
        @(negedge clk);
        Num_Edges = 8'd5; Gap = 4'd3; Strength = 3'd4; Chan_Mask = 4'hF; Start = 1'b1;
        @(posedge clk);
        @(negedge clk); Start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        chk("pre_rst_count", 32'(Edge_Count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_count", 32'(Edge_Count), 32'd0);
        chk("midrst_edges", 32'(Next_Edge_LowV), 32'd0);
        chk("midrst_drive", 32'(Drive_En), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        level = '0;
        run_burst(2, 1, 2, 4'h3, 16'h0033, 2, 1'b0);

`ifdef CHAIN_DRV_ABORT_EN
        // Abort in GAP after the fourth toggle (toggles at k+2,k+4,k+6,k+8).
        @(negedge clk);
        Num_Edges = 8'd10; Gap = 4'd1; Strength = 3'd1; Chan_Mask = 4'h1; Start = 1'b1;
        @(posedge clk);
        @(negedge clk); Start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("ab_pre_count", 32'(Edge_Count), 32'd4);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        chk("ab_done", 32'(Done), 32'd1);
        chk("ab_aborted", 32'(Aborted), 32'd1);
        chk("ab_count", 32'(Edge_Count), 32'd4);
        chk("ab_edges", 32'(Next_Edge_LowV), 32'(level));
        @(negedge clk);
        chk("ab_hold", 32'(Aborted), 32'd1);
        chk("ab_busy", 32'(Busy), 32'd0);
`endif

        for (int r = 0; r < 30; r++) begin
            int n, g, s;
            logic [3:0] m;
            n = int'($urandom_range(12));
            g = int'($urandom_range(5));
            s = int'($urandom_range(7));
            m = 4'($urandom);
            run_burst(n, g, s, m, model_de(s, m), n, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
